// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud arithmetic
// used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Clock cycles per bit; truncating division matches the receive path.
    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Write-side port of the UART transmitter: byte strobe in, FIFO status out.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);

    logic [DATA_BITS-1:0]        pi_data;
    logic                        pi_flag;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    modport master (output pi_data, pi_flag, input full, fifo_level);
    modport slave  (input pi_data, pi_flag, output full, fifo_level);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with first-word fall-through read data; the head byte is visible
// on rd_data whenever empty is low.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          level
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          level_q, level_d;
    logic                 wr_ok, rd_ok;

    // Status comes from registered level, so a same-edge pop never admits a write into a full FIFO.
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: non-blocking assignments on every clocked register so all flops update from pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; level/pointers alone define validity, so this maps to plain RAM.
    always_ff @(posedge sys_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes sent LSB first at a fixed baud,
// with back-to-back frames chained directly from stop bit into start bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    uart_tx_if.slave   wr_if,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int CW = $clog2(BAUD_CNT_MAX + 1);
    localparam int IW = $clog2(DATA_BITS);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [LW-1:0]        fifo_level;
    logic                 pop;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (wr_if.pi_flag),
        .wr_data   (wr_if.pi_data),
        .rd_en     (pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign wr_if.full       = fifo_full;
    assign wr_if.fifo_level = fifo_level;

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    assign bit_end = (baud_cnt_q == CW'(BAUD_CNT_MAX - 1));

    // NOTE: blocking assignments here, with every output defaulted first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        pop        = 1'b0;

        if (state_q != ST_IDLE) baud_cnt_d = bit_end ? '0 : baud_cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                        tx_d      = shift_q[bit_idx_q + IW'(1)];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    // Chain the next queued byte so its start bit follows with no idle cycle.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != ST_IDLE);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-timeline model checked every cycle, an independent
// serial decoder on tx, and directed scenarios with hand-computed expectations.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1000;
    localparam int UART_BPS = 125;
    localparam int DEPTH    = 4;
    localparam int B        = CLK_FREQ / UART_BPS;  // 8 cycles per bit, 80 per frame

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic tx, tx_busy, tx_done;

    uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .UART_BPS   (UART_BPS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_if     (bus.slave),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    int compared   = 0;
    int mismatched = 0;
    int edge_no    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Model: bytes waiting in a queue, plus the edge on which the current frame's start bit began.
    logic [7:0] mq[$];
    bit         in_flight = 1'b0;
    int         frame_start = 0;
    logic [7:0] frame_byte = 8'h00;
    bit         exp_done = 1'b0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mq.delete();
            in_flight = 1'b0;
            exp_done  = 1'b0;
        end else begin
            bit was_full;
            edge_no++;
            was_full = (mq.size() == DEPTH);
            exp_done = 1'b0;
            if (in_flight && (edge_no - frame_start) == 10 * B) begin
                exp_done  = 1'b1;
                in_flight = 1'b0;
            end
            if (!in_flight && mq.size() > 0) begin
                frame_byte  = mq.pop_front();
                frame_start = edge_no;
                in_flight   = 1'b1;
            end
            if (bus.pi_flag && !was_full) mq.push_back(bus.pi_data);
        end
    end

    function automatic logic exp_tx();
        int slot;
        if (!in_flight) return 1'b1;
        slot = (edge_no - frame_start) / B;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return frame_byte[slot-1];
        return 1'b1;
    endfunction

    bit started = 1'b0;
    int peak_level = 0;
    bit full_seen = 1'b0;
    int done_edges[$];

    always @(negedge sys_clk) begin
        if (started) begin
            check("tx", tx, exp_tx());
            check("tx_busy", tx_busy, in_flight);
            check("tx_done", tx_done, exp_done);
            check("fifo_level", bus.fifo_level, mq.size());
            check("full", bus.full, mq.size() == DEPTH);
            if (int'(bus.fifo_level) > peak_level) peak_level = int'(bus.fifo_level);
            if (bus.full) full_seen = 1'b1;
            if (tx_done) done_edges.push_back(edge_no);
        end
    end

    // Serial decoder on the line, sampling mid-bit; stands in for the receive path.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    int         frm_err = 0;

    always @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % B == B / 2) begin
                int k;
                k = rx_cnt / B;
                if (k == 0) begin
                    if (tx !== 1'b0) frm_err++;
                end else if (k <= 8) begin
                    rx_sh[k-1] = tx;
                end else begin
                    if (tx !== 1'b1) frm_err++;
                    else rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    int last_wr_edge = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        bus.pi_flag = 1'b1;
        bus.pi_data = b;
        @(posedge sys_clk);
        #1;
        last_wr_edge = edge_no;
        bus.pi_flag  = 1'b0;
    endtask

    task automatic wait_dones(input string name, input int target, input int budget);
        int n = 0;
        while (done_edges.size() < target && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_done_count"}, done_edges.size(), target);
    endtask

    task automatic wait_not_full(input int budget);
        int n = 0;
        while (bus.full && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_not_full", bus.full, 1'b0);
    endtask

    initial begin
        int base;
        int w;
        bus.pi_flag = 1'b0;
        bus.pi_data = 8'h00;
        sys_rst_n   = 1'b0;

        check("pkg_baud_default", baud_cnt_max(50_000_000, 9600), 5208);

        // Reset, with write strobes toggled while it is held
        tick(2);
        started = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.pi_flag = ~bus.pi_flag;
            bus.pi_data = 8'(8'hC0 + i);
            tick(1);
        end
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_full", bus.full, 1'b0);
        check("rst_level", bus.fifo_level, 0);
        bus.pi_flag = 1'b0;
        sys_rst_n   = 1'b1;
        tick(20);
        check("post_rst_level", bus.fifo_level, 0);
        check("post_rst_busy", tx_busy, 1'b0);
        check("post_rst_frames", rx_q.size(), 0);

        // Single byte 0x55
        base = done_edges.size();
        put(8'h55);
        w = last_wr_edge;
        wait_dones("single", base + 1, 200);
        if (done_edges.size() > base)
            check("single_done_latency", done_edges[base] - w, 81);  // 1 + 10*8
        tick(10);
        check("single_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("single_rx_byte", rx_q[0], 8'h55);

        // Four back-to-back writes
        rx_q.delete();
        base = done_edges.size();
        peak_level = 0;
        full_seen  = 1'b0;
        for (int i = 0; i < 4; i++) put(8'(i));
        w = last_wr_edge - 3;
        wait_dones("b2b", base + 4, 500);
        check("b2b_peak_level", peak_level, 3);
        check("b2b_full_seen", full_seen, 1'b0);
        if (done_edges.size() >= base + 4) begin
            check("b2b_first_latency", done_edges[base] - w, 81);
            for (int k = 0; k < 3; k++)
                check($sformatf("b2b_spacing_%0d", k), done_edges[base+k+1] - done_edges[base+k], 80);
        end
        tick(10);
        check("b2b_rx_count", rx_q.size(), 4);
        for (int k = 0; k < 4 && k < rx_q.size(); k++)
            check($sformatf("b2b_rx_%0d", k), rx_q[k], 8'(k));

        // Overflow: A0 in flight, A1-A4 fill the FIFO, A5/A6 dropped
        rx_q.delete();
        base = done_edges.size();
        put(8'hA0);
        tick(9);
        for (int i = 1; i <= 4; i++) put(8'(8'hA0 + i));
        check("ovf_full_after_a4", bus.full, 1'b1);
        check("ovf_level_after_a4", bus.fifo_level, 4);
        put(8'hA5);
        put(8'hA6);
        check("ovf_level_after_a6", bus.fifo_level, 4);
        wait_dones("ovf", base + 5, 700);
        tick(100);
        check("ovf_total_dones", done_edges.size(), base + 5);
        check("ovf_rx_count", rx_q.size(), 5);
        for (int k = 0; k < 5 && k < rx_q.size(); k++)
            check($sformatf("ovf_rx_%0d", k), rx_q[k], 8'(8'hA0 + k));

        // Reset during data bit 3 of 0xFF
        rx_q.delete();
        base = done_edges.size();
        put(8'hFF);
        tick(36);
        check("mid_busy_before_rst", tx_busy, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_level", bus.fifo_level, 0);
        tick(3);
        sys_rst_n = 1'b1;
        tick(120);
        check("mid_rst_no_done", done_edges.size(), base);
        check("mid_rst_no_frame", rx_q.size(), 0);
        check("mid_rst_idle_tx", tx, 1'b1);

        // Loopback of 0x00-0x07 through the decoder
        rx_q.delete();
        frm_err = 0;
        base = done_edges.size();
        for (int i = 0; i < 8; i++) begin
            wait_not_full(200);
            put(8'(i));
        end
        wait_dones("loop", base + 8, 1000);
        tick(10);
        check("loop_rx_count", rx_q.size(), 8);
        for (int k = 0; k < 8 && k < rx_q.size(); k++)
            check($sformatf("loop_rx_%0d", k), rx_q[k], 8'(k));
        check("loop_framing_errors", frm_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the board-to-host direction of the RS232 link. It accepts bytes from on-chip logic through a write strobe into a small FIFO. It emits them on `tx` as 8N1 frames, LSB first, at a fixed baud rate, with no idle gap between queued frames. It is the transmit-side counterpart of the existing UART receive path in the HDMI/RS232 design and uses the same baud arithmetic.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `UART_BPS`, default 9600: baud rate.
- `FIFO_DEPTH`, default 4: byte FIFO depth. Must be a power of 2 and ≥2.

- `sys_clk`, in, 1: single clock, rising-edge.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `pi_data`, in, 8: byte to transmit.
- `pi_flag`, in, 1: write strobe. `pi_data` is enqueued on an edge where `pi_flag`=1 and `full`=0.
- `full`, out, 1: FIFO holds `FIFO_DEPTH` bytes.
- `fifo_level`, out, clog2(`FIFO_DEPTH`)+1: number of bytes queued, excluding the frame in flight.
- `tx`, out, 1: serial line, idle high.
- `tx_busy`, out, 1: high while the FSM is not in IDLE.
- `tx_done`, out, 1: one-cycle pulse at the end of each frame's stop bit.

## Operation
- `BAUD_CNT_MAX` = `CLK_FREQ`/`UART_BPS` (integer division), giving 5208 at the defaults.
- Each bit is held exactly `BAUD_CNT_MAX` cycles. A frame is 10·`BAUD_CNT_MAX` cycles (52080 at the defaults).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START: on any edge with FIFO non-empty. That edge pops the head byte into the shift register and drives `tx`=0.
  - START → DATA: after `BAUD_CNT_MAX` cycles. Bit index is 0.
  - DATA: drives `tx`=shift[idx] and advances idx every `BAUD_CNT_MAX` cycles. After idx 7 completes, go to STOP.
  - STOP: drives `tx`=1 for `BAUD_CNT_MAX` cycles. On the final edge of the stop bit, `tx_done`=1 for the next cycle only.
    - If the FIFO is non-empty on that edge, pop and go directly to START, so `tx` falls on the same edge.
    - Otherwise go to IDLE.
- Baud counter: counts 0..`BAUD_CNT_MAX`-1, is cleared at every bit boundary, and is held at 0 in IDLE.
- `tx` is a registered output. It is never combinationally derived.
- Write while `full`=1: the write is silently dropped and no state changes. `full` is evaluated at the start of the cycle, so a simultaneous pop does not admit the write.
- Write and pop on the same edge with FIFO non-empty: `fifo_level` is unchanged.
- Write to an empty FIFO while IDLE: the byte is popped on the following edge, not the write edge.
- Reset asserted mid-frame, asynchronously:
  - `tx`→1, FSM→IDLE, FIFO cleared, counters cleared.
  - The truncated frame produces no `tx_done`.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `full`=0, `fifo_level`=0.
- Latency from write to start bit: a write on edge N into an empty FIFO with the FSM in IDLE drives `tx` low from edge N+1.
- End of frame: the stop bit ends at edge N+1+10·`BAUD_CNT_MAX`, and `tx_done` is high for the cycle following that edge.
- `tx_busy` rises on the edge `tx` first falls. It falls on the edge the FSM enters IDLE.
- Back-to-back frames have zero idle cycles between stop bit and next start bit.

## Structure
- Shared package `uart_pkg` holds:
  - state encodings (IDLE/START/DATA/STOP);
  - `DATA_BITS`=8;
  - the `BAUD_CNT_MAX` computation function, used identically by the receive path.
- Sub-module `uart_tx_fifo` is a synchronous FIFO with async active-low reset and ports wr_en/wr_data/rd_en/rd_data/full/empty/level. Its read data is valid in the same cycle as `empty`=0 (first-word fall-through).
- The FSM, baud counter and shift register stay in `uart_tx`.

## Test plan
- Reset: hold `sys_rst_n`=0 → `tx`=1, `tx_busy`=0, `tx_done`=0, `full`=0, `fifo_level`=0. Toggle `pi_flag` during reset → no effect after release.
- Single byte: write 0x55 at edge N →
  - `tx` low over [N+1, N+5209);
  - then bits 1,0,1,0,1,0,1,0 at 5208 cycles each;
  - stop high;
  - one `tx_done` pulse after edge N+52081.
- Back-to-back: write 0x00,0x01,0x02,0x03 on four consecutive edges →
  - `full` never asserts, and `fifo_level` peaks at 3;
  - four contiguous frames with no idle gap;
  - four `tx_done` pulses spaced exactly 52080 cycles.
- Overflow: write 0xA0, wait 10 cycles, then write 0xA1–0xA6 on consecutive edges →
  - `full`=1 after 0xA4;
  - 0xA5 and 0xA6 are dropped;
  - the line carries exactly 0xA0–0xA4.
- Reset mid-frame: send 0xFF and assert reset during data bit 3 → `tx`=1 within the reset, no `tx_done`, `fifo_level`=0, and no frame follows release.
- Loopback: connect `tx` to the team's UART receive path and send 0x00–0x07 → received bytes match in order with no framing errors.
